// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, lane masks and lane legality check for dmem_responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam logic [3:0] LANE_WORD    = 4'b1111;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_BYTE0   = 4'b1000;

  // wen bit3 is byte offset 0; a read (wen==0) is always lane-legal.
  function automatic logic lane_ok(input logic [3:0] wen, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (wen)
      4'b0000:                          ok = 1'b1;
      LANE_WORD, LANE_HALF_HI:          ok = (off == 2'b00);
      LANE_HALF_LO:                     ok = (off == 2'b10);
      4'b1000, 4'b0100, 4'b0010, 4'b0001: ok = (wen == (LANE_BYTE0 >> off));
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - four byte-wide RAM banks, per-lane write enables, synchronous write-before-read port
module dmem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [3:0]            i_we,
  input  logic                  i_re,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] r_mem [2**ADDR_WIDTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we[b]) r_mem[i_addr] <= i_wdata[8*b +: 8];
    end

    // Same-address write forwards the new byte into the read register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_q <= 8'h00;
      else if (i_re) r_q <= i_we[b] ? i_wdata[8*b +: 8] : r_mem[i_addr];
    end

    assign o_rdata[8*b +: 8] = r_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage data-memory responder; DMEM_WAIT_EN enables the wait-state FSM and busy_o
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_aw
    $error("dmem_responder: ADDR_WIDTH out of range");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("dmem_responder: BASE_ADDR not word aligned");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES out of range");
  end

  logic        w_go;
  logic        w_busy;
  logic [3:0]  w_acc_wen;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;

`ifdef DMEM_WAIT_EN
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  dmem_state_e r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_latch;
  logic [3:0]  r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wen   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_wen   <= wen_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
    end
  end

  // IDLE and DONE each take one busy cycle, WAIT fills the remaining WAIT_CYCLES-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    w_go        = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_busy      = 1'b1;
          w_latch     = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = (CNT_LOAD == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_go        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_acc_wen   = r_wen;
  assign w_acc_addr  = r_addr;
  assign w_acc_wdata = r_wdata;
`else
  assign w_go        = req_i;
  assign w_busy      = 1'b0;
  assign w_acc_wen   = wen_i;
  assign w_acc_addr  = addr_i;
  assign w_acc_wdata = wdata_i;
`endif

  logic [31:0] w_off;
  logic        w_err;
  logic        w_is_rd;
  logic [3:0]  w_ram_we;
  logic        w_ram_re;
  logic [31:0] w_ram_q;

  assign w_off    = w_acc_addr - BASE_ADDR;
  assign w_err    = (|w_off[31:ADDR_WIDTH+2]) | ~lane_ok(w_acc_wen, w_off[1:0]);
  assign w_is_rd  = (w_acc_wen == 4'b0000);
  assign w_ram_we = (w_go && !w_err) ? w_acc_wen : 4'b0000;
  assign w_ram_re = w_go & w_is_rd & ~w_err;

  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (w_off[ADDR_WIDTH+1:2]),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_q)
  );

  logic r_ready;
  logic r_err;
  logic r_zero;

  // r_zero masks the RAM read register after an erroneous read until the next legal read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_ready <= w_go;
      r_err   <= w_go & w_err;
      if (w_go && w_is_rd) r_zero <= w_err;
    end
  end

  assign rdata_o = r_zero ? 32'h0 : w_ram_q;
  assign ready_o = r_ready;
  assign err_o   = r_err;
  assign busy_o  = w_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with directed vectors
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [3:0]  wen_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        busy_o;
  logic        err_o;

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH  (10),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .wen_i   (wen_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready_o pulse consumes one expected response.
  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_err", {31'd0, err_o}, {31'd0, e.err});
        if (e.is_rd) chk("resp_rdata", rdata_o, e.data);
      end
    end
  end

  task automatic wait_ready();
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
      n++;
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_data);
    exp_t e;
    e.is_rd = (wen == 4'b0000);
    e.err   = exp_err;
    e.data  = exp_data;
    q.push_back(e);
    req_i   = 1'b1;
    wen_i   = wen;
    addr_i  = addr;
    wdata_i = wdata;
    @(posedge clk);
    #1;
    req_i = 1'b0;
`ifdef DMEM_WAIT_EN
    wait_ready();
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_i = 1'b0;
    wen_i = 4'd0;
    addr_i = 32'd0;
    wdata_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o},  32'd0);
    chk("rst_err",   {31'd0, err_o},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(4'b0000, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
    issue(4'b0100, 32'h11, 32'h5A5A5A5A, 1'b0, 32'h0);
    issue(4'b0000, 32'h10, 32'h0,        1'b0, 32'hDE5ABEEF);
    issue(4'b0011, 32'h11, 32'h12341234, 1'b1, 32'h0);
    issue(4'b0000, 32'h10, 32'h0,        1'b0, 32'hDE5ABEEF);
    issue(4'b0011, 32'h12, 32'h12341234, 1'b0, 32'h0);
    issue(4'b0000, 32'h10, 32'h0,        1'b0, 32'hDE5A1234);
    issue(4'b1100, 32'h10, 32'hABCDABCD, 1'b0, 32'h0);
    issue(4'b1111, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(4'b1010, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(4'b1000, 32'h12, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(4'b0000, 32'h10, 32'h0,        1'b0, 32'hABCD1234);
    issue(4'b0001, 32'h13, 32'h77777777, 1'b0, 32'h0);
    issue(4'b1000, 32'h10, 32'h99999999, 1'b0, 32'h0);
    issue(4'b0000, 32'h10, 32'h0,        1'b0, 32'h99CD1277);

    // Out-of-range accesses; a dropped write must not alias onto word 0.
    issue(4'b1111, 32'h0,    32'hCAFEF00D, 1'b0, 32'h0);
    issue(4'b0000, 32'h1000, 32'h0,        1'b1, 32'h0);
    issue(4'b1111, 32'h1000, 32'h11111111, 1'b1, 32'h0);
    issue(4'b0000, 32'h0,    32'h0,        1'b0, 32'hCAFEF00D);
    issue(4'b1111, 32'hFFC,  32'h5555AAAA, 1'b0, 32'h0);
    issue(4'b0000, 32'hFFC,  32'h0,        1'b0, 32'h5555AAAA);

    // Back-to-back write then read of the same word, then rdata_o must hold.
    issue(4'b1111, 32'h24, 32'h01234567, 1'b0, 32'h0);
    issue(4'b0000, 32'h24, 32'h0,        1'b0, 32'h01234567);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdata_o, 32'h01234567);
    @(posedge clk);
    #1;

`ifdef DMEM_WAIT_EN
    begin
      exp_t e;
      int nb;
      int rc;
      e.is_rd = 1'b1;
      e.err   = 1'b0;
      e.data  = 32'h99CD1277;
      q.push_back(e);
      req_i = 1'b1;
      wen_i = 4'b0000;
      addr_i = 32'h10;
      nb = 0;
      rc = -1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (busy_o) nb++;
        if (ready_o && rc < 0) rc = c;
        @(posedge clk);
        #1;
        req_i = 1'b0;
      end
      chk("wait_busy_cycles", nb, 32'd3);
      chk("wait_ready_cycle", rc, 32'd3);
    end

    issue(4'b1111, 32'h20, 32'h0BADF00D, 1'b0, 32'h0);
    begin
      int nr;
      req_i = 1'b1;
      wen_i = 4'b1111;
      addr_i = 32'h20;
      wdata_i = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      req_i = 1'b0;
      chk("mid_busy_before_rst", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_busy_async", {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      nr = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (ready_o) nr++;
      end
      chk("no_ready_after_rst", nr, 32'd0);
      @(posedge clk);
      #1;
    end
    issue(4'b0000, 32'h20, 32'h0, 1'b0, 32'h0BADF00D);
`else
    req_i = 1'b1;
    wen_i = 4'b0000;
    addr_i = 32'h10;
    #1;
    chk("busy_tied_low", {31'd0, busy_o}, 32'd0);
    q.push_back('{is_rd: 1'b1, err: 1'b0, data: 32'h99CD1277});
    @(posedge clk);
    #1;
    req_i = 1'b0;
`endif

    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the CPU's memory-stage interface. It accepts the byte address, lane-replicated write data and 4-bit big-endian byte enables driven from the M stage, and commits writes into an internal word RAM. It returns whole read words that the W stage lane-extracts itself. It flags illegal accesses and, optionally, inserts wait states with a stall request that the hazard unit consumes.

## Interface
Parameters:
- ADDR_WIDTH, 10: RAM depth is 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- WAIT_CYCLES, 2: extra cycles per access; only used when DMEM_WAIT_EN is defined; legal range 1..15.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- req_i, input, 1: access valid this cycle.
- wen_i, input, 4: byte enables; bit3 is bits[31:24] (byte offset 0) and bit0 is bits[7:0] (offset 3); 4'b0000 means read.
- addr_i, input, 32: byte address.
- wdata_i, input, 32: write data, already lane-replicated by the initiator.
- rdata_o, output, 32: registered read word.
- ready_o, output, 1: one-cycle pulse marking access completion.
- busy_o, output, 1: stall request to the hazard unit.
- err_o, output, 1: one-cycle pulse, accompanies ready_o for an illegal access.

## Operation
- Word index = (addr_i - BASE_ADDR) >> 2.
- Range error: the word index is ≥ 2^ADDR_WIDTH.
- Lane error, write accesses only:
  - wen 1111 requires addr[1:0]==00.
  - wen 1100 requires addr[1:0]==00; wen 0011 requires addr[1:0]==10.
  - A single-bit wen must equal 4'b1000 >> addr[1:0].
  - Any other non-zero pattern is an error.
- Reads have no lane check: they always return the full word.
- An erroneous access never modifies the RAM. An erroneous read returns 32'h0.
- Legal write: only enabled byte lanes are updated; the other lanes keep their previous contents.
- Same-word write then read on consecutive cycles: the read returns the newly written data, because the write commits before the read edge.
- req_i=0: no RAM access, and rdata_o holds its value.

## Timing
- Reset values: rdata_o=0, ready_o=0, busy_o=0, err_o=0, FSM in IDLE. RAM contents are not reset.
- Without DMEM_WAIT_EN:
  - One request is accepted per cycle.
  - A write commits at the edge where req_i is sampled.
  - rdata_o, ready_o and err_o are valid in the following cycle, which is one-cycle latency and matches the W-stage register.
  - busy_o is tied to 0.
- With DMEM_WAIT_EN, the FSM has states IDLE, WAIT, DONE:
  - IDLE & req_i: latch addr, wen and wdata; load the counter with WAIT_CYCLES-1; go to WAIT. busy_o is asserted combinationally in this same cycle.
  - WAIT: busy_o=1; decrement the counter; at 0, go to DONE.
  - DONE edge: commit the write or capture the read, then return to IDLE. busy_o drops at the DONE edge.
  - In the cycle after DONE, ready_o, err_o and rdata_o are valid and busy_o=0.
  - Total latency is WAIT_CYCLES+1 cycles from request to ready_o.
  - req_i is ignored while not in IDLE. The initiator holds its request stable because it is stalled.
  - A new request can be accepted in the cycle ready_o is high.
- Reset asserted mid-access: the FSM returns to IDLE immediately, the pending write is discarded (RAM unchanged), and no ready_o is issued.

## Configuration
- DMEM_WAIT_EN defined: wait-state FSM, counter and busy_o are generated.
- DMEM_WAIT_EN undefined: single-cycle responder, busy_o=0, and WAIT_CYCLES is unused.

## Structure
- Package dmem_pkg holds:
  - the FSM state enum (IDLE/WAIT/DONE);
  - the lane-mask constants for byte and half;
  - the legality function lane_ok(wen, addr[1:0]).
- Sub-module dmem_ram: four byte-wide banks with per-lane write enables, a synchronous read port, and write-before-read for the same address.
- dmem_responder owns decode, error logic, the FSM and the output registers.

## Test plan
- After reset, all outputs are 0. Write wen=1111, addr=0x10, wdata=0xDEADBEEF, then read 0x10 → rdata_o=0xDEADBEEF, ready_o pulse, err_o=0.
- Byte write wen=0100, addr=0x11, wdata=0x5A5A5A5A over 0xDEADBEEF, then read 0x10 → 0xDE5ABEEF.
- Half write wen=0011, addr=0x11 → err_o=1, RAM unchanged; a subsequent read of 0x10 still returns the prior word.
- Read at BASE_ADDR + 4·2^ADDR_WIDTH → err_o=1, rdata_o=0; a write to that address is dropped.
- DMEM_WAIT_EN with WAIT_CYCLES=2:
  - Read request → busy_o high for 3 cycles (the request cycle plus 2), ready_o in cycle 4.
  - Back-to-back write then read of the same word → read returns the new data.
- DMEM_WAIT_EN: assert rst during WAIT of a write to 0x20 → FSM goes to IDLE, no ready_o, and a read of 0x20 returns the old value.
